// File: rtl/neuron_run_sequencer.sv
// ----------------------------------------------------------------------------
// neuron_run_sequencer
//
// Purpose:
//   Loads the synapse input and weight registers of a neuron datapath from a
//   byte stream, then runs the neuron for a requested number of enabled
//   timesteps and counts the spikes it produces. A run is a start/done
//   transaction and can be cut short with abort.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_byte_in/_valid        byte load stream; o_byte_ready high only in IDLE
//   i_byte_is_weight        1 = byte goes to weights, 0 = byte goes to inputs
//   i_start, i_steps        run request; steps sampled together with start
//   i_abort                 terminate a run in progress without done
//   i_spike_in              neuron spike output
//   o_neuron_clear          one-cycle pulse clearing neuron membrane state
//   o_neuron_enable         neuron timestep enable
//   o_inputs_out            synapse input register
//   o_weights_out           weight register
//   o_busy                  run in progress (RUN or DRAIN)
//   o_done                  one-cycle pulse at end of a completed run
//   o_spike_count           spikes counted in the last/current run
// ----------------------------------------------------------------------------
module neuron_run_sequencer #(
    parameter int SYNAPSES      = 32,
    parameter int STEPS_BITS    = 8,
    parameter int SPIKE_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [7:0]            i_byte_in,
    input  logic                  i_byte_valid,
    input  logic                  i_byte_is_weight,
    output logic                  o_byte_ready,
    input  logic                  i_start,
    input  logic [STEPS_BITS-1:0] i_steps,
    input  logic                  i_abort,
    input  logic                  i_spike_in,
    output logic                  o_neuron_clear,
    output logic                  o_neuron_enable,
    output logic [SYNAPSES-1:0]   o_inputs_out,
    output logic [SYNAPSES-1:0]   o_weights_out,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [STEPS_BITS-1:0] o_spike_count
);

    localparam int DRAIN_W = $clog2(SPIKE_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [SYNAPSES-1:0]     r_inputs;
    logic [SYNAPSES-1:0]     r_weights;
    logic [STEPS_BITS-1:0]   r_remaining;
    logic [STEPS_BITS-1:0]   r_spike_count;
    logic [DRAIN_W-1:0]      r_drain;
    logic [SPIKE_LATENCY-1:0] r_en_hist;
    logic                    r_byte_ready;
    logic                    r_clear;
    logic                    r_enable;
    logic                    r_busy;
    logic                    r_done;

    logic [SYNAPSES-1:0]      w_inputs_shift;
    logic [SYNAPSES-1:0]      w_weights_shift;
    logic [SPIKE_LATENCY-1:0] w_hist_next;
    logic                     w_accept;
    logic                     w_in_run;
    logic                     w_sample;
    logic                     w_count_full;

    // Byte shift-in: with an 8-bit register the byte simply replaces it.
    generate
        if (SYNAPSES == 8) begin : g_shift8
            assign w_inputs_shift  = i_byte_in;
            assign w_weights_shift = i_byte_in;
        end else begin : g_shiftn
            assign w_inputs_shift  = {r_inputs[SYNAPSES-9:0], i_byte_in};
            assign w_weights_shift = {r_weights[SYNAPSES-9:0], i_byte_in};
        end
    endgenerate

    // Enable history: bit k holds the enable seen k+1 cycles ago, so the top
    // bit says whether this cycle's spike_in belongs to an enabled timestep.
    generate
        if (SPIKE_LATENCY == 1) begin : g_hist1
            assign w_hist_next = r_enable;
        end else begin : g_histn
            assign w_hist_next = {r_en_hist[SPIKE_LATENCY-2:0], r_enable};
        end
    endgenerate

    assign w_accept     = i_byte_valid & r_byte_ready;
    assign w_in_run     = (r_state == S_RUN) || (r_state == S_DRAIN);
    // Gate on RUN/DRAIN so stale history never counts after leaving a run.
    assign w_sample     = w_in_run & r_en_hist[SPIKE_LATENCY-1] & i_spike_in;
    assign w_count_full = &r_spike_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_inputs      <= '0;
            r_weights     <= '1;
            r_remaining   <= '0;
            r_spike_count <= '0;
            r_drain       <= '0;
            r_en_hist     <= '0;
            r_byte_ready  <= 1'b1;
            r_clear       <= 1'b0;
            r_enable      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_clear   <= 1'b0;
            r_done    <= 1'b0;
            r_en_hist <= w_hist_next;

            if (w_accept) begin
                if (i_byte_is_weight) r_weights <= w_weights_shift;
                else                  r_inputs  <= w_inputs_shift;
            end

            // Saturating spike counter.
            if (w_sample && !w_count_full)
                r_spike_count <= r_spike_count + STEPS_BITS'(1);

            case (r_state)
                S_IDLE: begin
                    // Start has priority over abort here; abort is a no-op in IDLE.
                    if (i_start) begin
                        r_remaining   <= i_steps;
                        r_spike_count <= '0;
                        r_clear       <= 1'b1;
                        r_byte_ready  <= 1'b0;
                        if (i_steps != '0) begin
                            r_state  <= S_RUN;
                            r_enable <= 1'b1;
                            r_busy   <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (i_abort) begin
                        r_state      <= S_IDLE;
                        r_enable     <= 1'b0;
                        r_busy       <= 1'b0;
                        r_byte_ready <= 1'b1;
                        r_en_hist    <= '0;
                    end else if (r_remaining == STEPS_BITS'(1)) begin
                        // Last enabled step is this cycle; wait out the spike latency.
                        r_state  <= S_DRAIN;
                        r_enable <= 1'b0;
                        r_drain  <= DRAIN_W'(SPIKE_LATENCY);
                    end else begin
                        r_remaining <= r_remaining - STEPS_BITS'(1);
                    end
                end

                S_DRAIN: begin
                    if (i_abort) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_byte_ready <= 1'b1;
                        r_en_hist    <= '0;
                    end else if (r_drain == DRAIN_W'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - DRAIN_W'(1);
                    end
                end

                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_byte_ready <= 1'b1;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_enable     <= 1'b0;
                    r_busy       <= 1'b0;
                    r_byte_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_byte_ready    = r_byte_ready;
    assign o_neuron_clear  = r_clear;
    assign o_neuron_enable = r_enable;
    assign o_inputs_out    = r_inputs;
    assign o_weights_out   = r_weights;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_spike_count   = r_spike_count;

endmodule

// File: tb/tb_neuron_run_sequencer.sv
// ----------------------------------------------------------------------------
// tb_neuron_run_sequencer
//
// Scoreboarded bench: each run request pushes its expected outcome (spike
// count, start-to-done latency, number of enabled cycles) into a queue; a
// negedge monitor pops an entry whenever done pulses and compares. Expected
// spike counts come from the spike pattern driven on spike_in: a sample in
// cycle j after start counts iff an enabled step happened SPIKE_LATENCY
// cycles earlier, i.e. SPIKE_LATENCY < j <= steps + SPIKE_LATENCY.
// ----------------------------------------------------------------------------
module tb_neuron_run_sequencer;

    localparam int SYN = 32;
    localparam int SB  = 8;
    localparam int SL  = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     byte_in = '0;
    logic           byte_valid = 1'b0;
    logic           byte_is_weight = 1'b0;
    logic           byte_ready;
    logic           start = 1'b0;
    logic [SB-1:0]  steps = '0;
    logic           abort = 1'b0;
    logic           spike_in = 1'b0;
    logic           neuron_clear;
    logic           neuron_enable;
    logic [SYN-1:0] inputs_out;
    logic [SYN-1:0] weights_out;
    logic           busy;
    logic           done;
    logic [SB-1:0]  spike_count;

    neuron_run_sequencer #(
        .SYNAPSES(SYN), .STEPS_BITS(SB), .SPIKE_LATENCY(SL)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .i_byte_in(byte_in), .i_byte_valid(byte_valid),
        .i_byte_is_weight(byte_is_weight), .o_byte_ready(byte_ready),
        .i_start(start), .i_steps(steps), .i_abort(abort),
        .i_spike_in(spike_in),
        .o_neuron_clear(neuron_clear), .o_neuron_enable(neuron_enable),
        .o_inputs_out(inputs_out), .o_weights_out(weights_out),
        .o_busy(busy), .o_done(done), .o_spike_count(spike_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int steps;
        int count;
        int lat;
        int drive_cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    logic [SYN-1:0] m_in;
    logic [SYN-1:0] m_w;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [SYN-1:0] shl(input logic [SYN-1:0] r, input logic [7:0] b);
        return (r << 8) | SYN'(b);
    endfunction

    // Monitor: counts enables/clears per run and checks each done against the queue.
    int en_cnt  = 0;
    int clr_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (!busy && !done && !neuron_clear) begin
                en_cnt  = 0;
                clr_cnt = 0;
            end
            if (neuron_clear)  clr_cnt++;
            if (neuron_enable) en_cnt++;
            if (busy) chk("ready_low_while_busy", 64'(byte_ready), 64'd0);
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("spike_count", 64'(spike_count), 64'(mon_e.count));
                    chk("latency", 64'(cyc - mon_e.drive_cyc), 64'(mon_e.lat));
                    chk("enable_cycles", 64'(en_cnt), 64'(mon_e.steps));
                    chk("clear_pulses", 64'(clr_cnt), 64'd1);
                    chk("busy_at_done", 64'(busy), 64'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic w, input logic [7:0] b);
        tick();
        byte_valid     = 1'b1;
        byte_is_weight = w;
        byte_in        = b;
        if (w) m_w = shl(m_w, b);
        else   m_in = shl(m_in, b);
        tick();
        byte_valid = 1'b0;
    endtask

    // mode: 0 random spikes, 1 all ones, 2 all zeros
    task automatic do_run(input int s, input int mode, input bit hold, input bit offer);
        bit pat [0:300];
        int exp_cnt;
        int lat;
        logic [7:0] b;
        logic w;
        exp_cnt = 0;
        for (int j = 0; j <= 300; j++)
            pat[j] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        for (int j = 1; j <= 300; j++)
            if (j > SL && j <= s + SL && pat[j]) exp_cnt++;
        if (exp_cnt > (1 << SB) - 1) exp_cnt = (1 << SB) - 1;
        lat = (s == 0) ? 1 : s + SL + 1;

        tick();
        start    = 1'b1;
        steps    = SB'(s);
        spike_in = pat[0];
        if (offer) begin
            b = 8'($urandom);
            w = 1'($urandom_range(0, 1));
            byte_valid     = 1'b1;
            byte_in        = b;
            byte_is_weight = w;
            if (w) m_w = shl(m_w, b);
            else   m_in = shl(m_in, b);
        end
        sbq.push_back('{s, exp_cnt, lat, cyc});

        for (int j = 1; j <= lat + 1; j++) begin
            tick();
            start    = hold && (j <= s);
            spike_in = pat[j];
            if (offer && j <= lat) begin
                byte_valid     = 1'b1;
                byte_in        = 8'($urandom);
                byte_is_weight = 1'($urandom_range(0, 1));
            end else begin
                byte_valid = 1'b0;
            end
        end
        start      = 1'b0;
        spike_in   = 1'b0;
        byte_valid = 1'b0;

        chk("done_seen", 64'(sbq.size()), 64'd0);
        if (sbq.size() != 0) sbq.delete();
        chk("inputs_reg", 64'(inputs_out), 64'(m_in));
        chk("weights_reg", 64'(weights_out), 64'(m_w));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        m_in = '0;
        m_w  = '1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_enable", 64'(neuron_enable), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_clear", 64'(neuron_clear), 64'd0);
        chk("rst_ready", 64'(byte_ready), 64'd1);
        chk("rst_inputs", 64'(inputs_out), 64'd0);
        chk("rst_weights", 64'(weights_out), 64'hFFFF_FFFF);
        chk("rst_count", 64'(spike_count), 64'd0);
        rst = 1'b0;
        tick();

        // Reset in the middle of a run
        load_byte(1'b0, 8'h5A);
        load_byte(1'b1, 8'h3C);
        spike_in = 1'b1;
        tick();
        start = 1'b1;
        steps = SB'(10);
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("midrun_enable", 64'(neuron_enable), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_enable", 64'(neuron_enable), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_weights", 64'(weights_out), 64'hFFFF_FFFF);
        chk("midrst_inputs", 64'(inputs_out), 64'd0);
        chk("midrst_count", 64'(spike_count), 64'd0);
        m_in = '0;
        m_w  = '1;
        spike_in = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_ready", 64'(byte_ready), 64'd1);
        tick();

        // Byte loading
        load_byte(1'b0, 8'h11);
        load_byte(1'b0, 8'h22);
        load_byte(1'b0, 8'h33);
        load_byte(1'b0, 8'h44);
        load_byte(1'b1, 8'hAA);
        load_byte(1'b1, 8'h55);
        chk("load_inputs", 64'(inputs_out), 64'h1122_3344);
        chk("load_weights", 64'(weights_out), 64'hFFFF_AA55);

        // Directed runs (bytes offered during the run must be ignored)
        do_run(5, 1, 1'b0, 1'b1);
        chk("busy_after_run", 64'(busy), 64'd0);
        do_run(0, 1, 1'b0, 1'b0);
        do_run(255, 1, 1'b0, 1'b0);
        do_run(3, 2, 1'b0, 1'b0);

        // Abort on the third RUN cycle, start held during busy
        spike_in = 1'b1;
        tick();
        start = 1'b1;
        steps = SB'(8);
        tick();
        start = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_enable", 64'(neuron_enable), 64'd0);
        chk("abort_count", 64'(spike_count), 64'd2);
        chk("abort_ready", 64'(byte_ready), 64'd1);
        repeat (10) tick();
        chk("abort_count_hold", 64'(spike_count), 64'd2);
        spike_in = 1'b0;
        tick();

        // Randomized runs
        repeat (20)
            do_run(int'($urandom_range(0, 40)), 0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
